multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Parameterised multicycle successor to the single-cycle RV32I control path. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It adds a memory ready handshake, the full branch set, jalr, lui and a 4-bit ALU code. It sits between the instruction register and the multicycle datapath (PC, IR, OldPC, ALUOut, Data registers).

Parameters:
ALU_CTRL_W, 4, width of alu_control; must be >=4; bits above [3] are driven 0.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
STATE_W, 4, width of the debug state output.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
instr  in  32  IR contents; stable from DECODE onward
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_w  out  1  write strobe; valid only with mem_req
adr_src  out  1  0 = PC, 1 = ALUOut
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result
reg_w  out  1  register file write
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
result_src  out  2  00 ALUOut, 01 Data, 10 ALU result
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra
instr_done  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  illegal-instruction flag (see Optional Feature)
state  out  STATE_W  current FSM state

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- While rst=1: state=FETCH and every output is forced to 0. The first fetch occurs in the first cycle after rst deasserts.
- Outputs are combinational decodes of the current state and of instr. Any output not listed for a state is 0.
- Unless stated otherwise, alu_control=add and imm_src is decoded from the opcode.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, add, result_src=10.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: src_a=01, src_b=01 (computes the branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 0110111 -> LUI
  - otherwise illegal.
- MEMADR: src_a=10, src_b=01, add. Loads -> MEMREAD; stores -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_w=1, instr_done=1, -> FETCH.
- MEMWRITE: mem_req=1, mem_w=1, adr_src=1. Wait for mem_ready; instr_done is asserted on the completing cycle; -> FETCH.
- EXEC_R: src_a=10, src_b=00. alu_control is decoded from funct3/funct7[5]: sub and sra use bit 5. -> ALUWB.
- EXEC_I: src_a=10, src_b=01.
  - funct7[5] is honoured only for shifts (srai); addi never subtracts.
  - -> ALUWB.
- ALUWB: result_src=00, reg_w=1, instr_done=1, -> FETCH.
- BRANCH: src_a=10, src_b=00, sub, result_src=00.
  - pc_write = taken, where funct3 000:zero, 001:!zero, 100:lt, 101:!lt, 110:ltu, 111:!ltu.
  - funct3 010/011 is illegal.
  - instr_done=1, -> FETCH.
- JAL: src_a=01, src_b=10, result_src=00 (target), pc_write=1, -> ALUWB (rd=OldPC+4).
- JALR_ADR: src_a=10, src_b=01, imm I, -> JALR.
- JALR: src_a=01, src_b=10, result_src=00 (rs1+imm), pc_write=1, -> ALUWB.
- LUI: src_a=11, src_b=01, imm U, -> ALUWB.
- Assertion of rst in any state, including a memory wait, aborts to FETCH asynchronously. No write strobe may be issued after rst rises.
- With MEM_HANDSHAKE=0, every memory state lasts exactly one cycle.
- Cycle counts with mem_ready tied to 1:
  - R/I/LUI: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal: 4
  - jalr: 5

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or branch funct3 enters TRAP. TRAP drives illegal=1 and all other outputs 0, and stays there until rst.
- Undefined: the illegal case goes directly to FETCH, executing as a NOP with PC already advanced. instr_done pulses, illegal stays 0, and TRAP does not exist.

Test Plan:
- rst=1 mid-MEMWRITE with mem_ready=0 -> all outputs 0 immediately; after release, FETCH with mem_req=1 and adr_src=0.
- add x3,x1,x2 (0x002081B3), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB; alu_control=0; reg_w in cycle 4; instr_done once.
- lw 0x0000A183 with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, mem_req=1, then MEMWB with result_src=01; 8 cycles total.
- Branch set: bne (funct3 001) with zero=0 -> pc_write=1 in BRANCH; bgeu (funct3 111) with ltu=1 -> pc_write=0; both take 3 cycles.
- jalr 0x000080E7 -> JALR_ADR then JALR with pc_write=1, then ALUWB with reg_w=1; 5 cycles.
- Opcode 0x0000007F -> with CTRL_ILLEGAL_TRAP_EN, illegal=1 held and no further mem_req; without it, back to FETCH with illegal=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bus of the multicycle RV32I controller: IR/flag/memory-ready inputs and datapath control outputs.
// The controller uses the master modport; the datapath (or a bench) uses the slave modport.
interface multicycle_controller_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int STATE_W    = 4
);
  logic [31:0]           instr;
  logic                  zero;
  logic                  lt;
  logic                  ltu;
  logic                  mem_ready;
  logic                  mem_req;
  logic                  mem_w;
  logic                  adr_src;
  logic                  ir_write;
  logic                  pc_write;
  logic                  reg_w;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [1:0]            result_src;
  logic [2:0]            imm_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  instr_done;
  logic                  illegal;
  logic [STATE_W-1:0]    state;

  modport master (
    input  instr, zero, lt, ltu, mem_ready,
    output mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, instr_done, illegal, state
  );

  modport slave (
    output instr, zero, lt, ltu, mem_ready,
    input  mem_req, mem_w, adr_src, ir_write, pc_write, reg_w, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing fetch/decode/execute/memory/writeback for a shared-ALU RV32I datapath.
// Define CTRL_ILLEGAL_TRAP_EN to lock illegal instructions in a TRAP state; otherwise they retire as NOPs.
module multicycle_controller #(
  parameter int ALU_CTRL_W    = 4,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int STATE_W       = 4
) (
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_ADR = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd14
`endif
  } state_e;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5);
    case (f3)
      3'b000:  alu_dec = b5 ? 4'd1 : 4'd0;
      3'b001:  alu_dec = 4'd7;
      3'b010:  alu_dec = 4'd5;
      3'b011:  alu_dec = 4'd6;
      3'b100:  alu_dec = 4'd4;
      3'b101:  alu_dec = b5 ? 4'd9 : 4'd8;
      3'b110:  alu_dec = 4'd3;
      default: alu_dec = 4'd2;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    case (f3)
      3'b000:  br_taken = z;
      3'b001:  br_taken = ~z;
      3'b100:  br_taken = l;
      3'b101:  br_taken = ~l;
      3'b110:  br_taken = lu;
      3'b111:  br_taken = ~lu;
      default: br_taken = 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d, dec_next_s;
  logic [6:0]  op_s;
  logic [2:0]  f3_s;
  logic        b5_s, rdy_s, legal_s;
  logic        mem_req_s, mem_w_s, adr_src_s, ir_write_s, pc_write_s, reg_w_s, done_s, illegal_s;
  logic [1:0]  src_a_s, src_b_s, result_s;
  logic [2:0]  imm_s, imm_dec_s;
  logic [3:0]  alu_s;
  logic        unused_bits_s;

  assign op_s  = bus.instr[6:0];
  assign f3_s  = bus.instr[14:12];
  assign b5_s  = bus.instr[30];
  assign rdy_s = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign unused_bits_s = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Immediate format follows the opcode in every state
  always_comb begin
    case (op_s)
      OP_STORE: imm_dec_s = 3'b001;
      OP_BR:    imm_dec_s = 3'b010;
      OP_JAL:   imm_dec_s = 3'b011;
      OP_LUI:   imm_dec_s = 3'b100;
      default:  imm_dec_s = 3'b000;
    endcase
  end

  // Opcode dispatch out of DECODE; reserved branch funct3 counts as illegal
  always_comb begin
    legal_s    = 1'b1;
    dec_next_s = S_FETCH;
    case (op_s)
      OP_LOAD, OP_STORE: dec_next_s = S_MEMADR;
      OP_R:              dec_next_s = S_EXEC_R;
      OP_I:              dec_next_s = S_EXEC_I;
      OP_BR: begin
        if (f3_s[2:1] == 2'b01) begin
          legal_s = 1'b0;
        end else begin
          dec_next_s = S_BRANCH;
        end
      end
      OP_JAL:            dec_next_s = S_JAL;
      OP_JALR:           dec_next_s = S_JALR_ADR;
      OP_LUI:            dec_next_s = S_LUI;
      default:           legal_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore control decode
  always_comb begin
    state_d    = state_q;
    mem_req_s  = 1'b0;
    mem_w_s    = 1'b0;
    adr_src_s  = 1'b0;
    ir_write_s = 1'b0;
    pc_write_s = 1'b0;
    reg_w_s    = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    src_a_s    = 2'b00;
    src_b_s    = 2'b00;
    result_s   = 2'b00;
    imm_s      = imm_dec_s;
    alu_s      = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req_s = 1'b1;
        src_b_s   = 2'b10;
        result_s  = 2'b10;
        if (rdy_s) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        src_a_s = 2'b01;
        src_b_s = 2'b01;
        if (legal_s) begin
          state_d = dec_next_s;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          done_s  = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_MEMADR: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        state_d = op_s[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
        state_d   = rdy_s ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_s = 2'b01;
        reg_w_s  = 1'b1;
        done_s   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s = 1'b1;
        mem_w_s   = 1'b1;
        adr_src_s = 1'b1;
        done_s    = rdy_s;
        state_d   = rdy_s ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC_R: begin
        src_a_s = 2'b10;
        alu_s   = alu_dec(f3_s, b5_s);
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        alu_s   = alu_dec(f3_s, b5_s & (f3_s == 3'b101));
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w_s = 1'b1;
        done_s  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_a_s    = 2'b10;
        alu_s      = ALU_SUB;
        pc_write_s = br_taken(f3_s, bus.zero, bus.lt, bus.ltu);
        done_s     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        src_a_s    = 2'b01;
        src_b_s    = 2'b10;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR_ADR: begin
        src_a_s = 2'b10;
        src_b_s = 2'b01;
        imm_s   = 3'b000;
        state_d = S_JALR;
      end
      S_JALR: begin
        src_a_s    = 2'b01;
        src_b_s    = 2'b10;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        src_a_s = 2'b11;
        src_b_s = 2'b01;
        imm_s   = 3'b100;
        state_d = S_ALUWB;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        imm_s     = 3'b000;
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Reset masks every control line so no strobe survives an asynchronous abort
  assign bus.mem_req     = mem_req_s  & ~rst;
  assign bus.mem_w       = mem_w_s    & ~rst;
  assign bus.adr_src     = adr_src_s  & ~rst;
  assign bus.ir_write    = ir_write_s & ~rst;
  assign bus.pc_write    = pc_write_s & ~rst;
  assign bus.reg_w       = reg_w_s    & ~rst;
  assign bus.instr_done  = done_s     & ~rst;
  assign bus.illegal     = illegal_s  & ~rst;
  assign bus.alu_src_a   = rst ? 2'b00 : src_a_s;
  assign bus.alu_src_b   = rst ? 2'b00 : src_b_s;
  assign bus.result_src  = rst ? 2'b00 : result_s;
  assign bus.imm_src     = rst ? 3'b000 : imm_s;
  assign bus.alu_control = rst ? {ALU_CTRL_W{1'b0}} : ALU_CTRL_W'(alu_s);
  assign bus.state       = STATE_W'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: a per-instruction cycle-sequence model, checked every cycle against the controller outputs.
module tb_multicycle_controller;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic       mem_req, mem_w, adr_src, ir_write, pc_write, reg_w;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       done, ill, rdy;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  cyc_t q[$];
  cyc_t exp_r;
  logic exp_valid = 1'b0;
  string cur_tag = "";
  logic [20:0] dut_v;

  multicycle_controller_if #(.ALU_CTRL_W(4), .STATE_W(4)) bus ();

  multicycle_controller #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(1'b1), .STATE_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign dut_v = {bus.mem_req, bus.mem_w, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_w,
                  bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src, bus.alu_control[3:0],
                  bus.instr_done, bus.illegal};

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Single compare point: DUT outputs against the model's expected cycle, mid-cycle
  always @(negedge clk) begin
    if (exp_valid) check({"cycle ", cur_tag}, 32'(dut_v), 32'(exp_r[21:1]));
  end

  function automatic cyc_t cy(input logic [5:0] ctl, input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] rs, input logic [2:0] imm, input logic [3:0] alu,
                              input logic done, input logic rdy);
    cyc_t c;
    {c.mem_req, c.mem_w, c.adr_src, c.ir_write, c.pc_write, c.reg_w} = ctl;
    c.sa = sa; c.sb = sb; c.rs = rs; c.imm = imm; c.alu = alu;
    c.done = done; c.ill = 1'b0; c.rdy = rdy;
    return c;
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic b5);
    logic [3:0] t [8];
    t = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'b000 && b5) return 4'd1;
    if (f3 == 3'b101 && b5) return 4'd9;
    return t[f3];
  endfunction

  // Builds the expected cycle-by-cycle outputs for one instruction from the ISA-level rules
  task automatic prep(input logic [31:0] ins, input logic z, input logic l, input logic lu,
                      input int fw, input int mw);
    logic [6:0] op;
    logic [2:0] f3, imm;
    logic       legal, taken;
    cyc_t       wb;
    op = ins[6:0];
    f3 = ins[14:12];
    bus.instr = ins; bus.zero = z; bus.lt = l; bus.ltu = lu;
    case (op)
      7'b0100011: imm = 3'b001;
      7'b1100011: imm = 3'b010;
      7'b1101111: imm = 3'b011;
      7'b0110111: imm = 3'b100;
      default:    imm = 3'b000;
    endcase
    legal = (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                        7'b1100111, 7'b0110111}) ||
            (op == 7'b1100011 && !(f3 inside {3'b010, 3'b011}));
    taken = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? l :
            (f3 == 3'b101) ? !l : (f3 == 3'b110) ? lu : !lu;
    wb = cy(6'b000001, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1'b1, 1'b1);
    q.delete();
    repeat (fw) q.push_back(cy(6'b100000, 2'b00, 2'b10, 2'b10, imm, 4'd0, 1'b0, 1'b0));
    q.push_back(cy(6'b100110, 2'b00, 2'b10, 2'b10, imm, 4'd0, 1'b0, 1'b1));
    q.push_back(cy(6'b000000, 2'b01, 2'b01, 2'b00, imm, 4'd0, !legal && !TRAP_EN, 1'b1));
    if (!legal) begin
      if (TRAP_EN) begin
        cyc_t t;
        t = '0; t.ill = 1'b1; t.rdy = 1'b1;
        repeat (4) q.push_back(t);
      end
      return;
    end
    case (op)
      7'b0000011: begin
        q.push_back(cy(6'b000000, 2'b10, 2'b01, 2'b00, imm, 4'd0, 1'b0, 1'b1));
        repeat (mw) q.push_back(cy(6'b101000, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1'b0, 1'b0));
        q.push_back(cy(6'b101000, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1'b0, 1'b1));
        q.push_back(cy(6'b000001, 2'b00, 2'b00, 2'b01, imm, 4'd0, 1'b1, 1'b1));
      end
      7'b0100011: begin
        q.push_back(cy(6'b000000, 2'b10, 2'b01, 2'b00, imm, 4'd0, 1'b0, 1'b1));
        repeat (mw) q.push_back(cy(6'b111000, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1'b0, 1'b0));
        q.push_back(cy(6'b111000, 2'b00, 2'b00, 2'b00, imm, 4'd0, 1'b1, 1'b1));
      end
      7'b0110011: begin
        q.push_back(cy(6'b000000, 2'b10, 2'b00, 2'b00, imm, alu_of(f3, ins[30]), 1'b0, 1'b1));
        q.push_back(wb);
      end
      7'b0010011: begin
        q.push_back(cy(6'b000000, 2'b10, 2'b01, 2'b00, imm,
                       alu_of(f3, ins[30] && f3 == 3'b101), 1'b0, 1'b1));
        q.push_back(wb);
      end
      7'b1100011:
        q.push_back(cy({4'b0000, taken, 1'b0}, 2'b10, 2'b00, 2'b00, imm, 4'd1, 1'b1, 1'b1));
      7'b1101111: begin
        q.push_back(cy(6'b000010, 2'b01, 2'b10, 2'b00, imm, 4'd0, 1'b0, 1'b1));
        q.push_back(wb);
      end
      7'b1100111: begin
        q.push_back(cy(6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 4'd0, 1'b0, 1'b1));
        q.push_back(cy(6'b000010, 2'b01, 2'b10, 2'b00, imm, 4'd0, 1'b0, 1'b1));
        q.push_back(wb);
      end
      default: begin
        q.push_back(cy(6'b000000, 2'b11, 2'b01, 2'b00, 3'b100, 4'd0, 1'b0, 1'b1));
        q.push_back(wb);
      end
    endcase
  endtask

  task automatic run(input string tag, input int n);
    int lim;
    lim = (n < 0) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      bus.mem_ready = q[i].rdy;
      exp_r         = q[i];
      cur_tag       = $sformatf("%s[%0d]", tag, i);
      exp_valid     = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    exp_valid = 1'b0;
    rst = 1'b1;
    #1 check({tag, "_rst_now"}, 32'(dut_v), 32'd0);
    @(posedge clk);
    #1 check({tag, "_rst_hold"}, 32'(dut_v), 32'd0);
    rst = 1'b0;
    #1;
  endtask

  task automatic go(input string tag, input logic [31:0] ins, input logic z, input logic l,
                    input logic lu);
    prep(ins, z, l, lu, 0, 0);
    run(tag, -1);
  endtask

  initial begin
    rst = 1'b1;
    bus.instr = 32'h002081B3; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", 32'(dut_v), 32'd0);
    rst = 1'b0;
    #1;

    prep(32'h002081B3, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_add_len", q.size(), 32'd4);
    check("model_add_regw", 32'(q[3].reg_w), 32'd1);
    run("add", -1);

    prep(32'h0000A183, 1'b0, 1'b0, 1'b0, 0, 3);
    check("model_lw_len", q.size(), 32'd8);
    check("model_lw_wb_src", 32'(q[7].rs), 32'd1);
    run("lw_wait3", -1);

    prep(32'h00209063, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_bne_len", q.size(), 32'd3);
    check("model_bne_taken", 32'(q[2].pc_write), 32'd1);
    run("bne", -1);

    prep(32'h0020F063, 1'b0, 1'b0, 1'b1, 0, 0);
    check("model_bgeu_nottaken", 32'(q[2].pc_write), 32'd0);
    run("bgeu", -1);

    go("beq_t", 32'h00208063, 1'b1, 1'b0, 1'b0);
    go("beq_n", 32'h00208063, 1'b0, 1'b1, 1'b1);
    go("blt_t", 32'h0020C063, 1'b0, 1'b1, 1'b0);
    go("bge_n", 32'h0020D063, 1'b0, 1'b1, 1'b0);
    go("bltu_n", 32'h0020E063, 1'b1, 1'b1, 1'b0);

    prep(32'h000080E7, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_jalr_len", q.size(), 32'd5);
    check("model_jalr_pcw", 32'(q[3].pc_write), 32'd1);
    run("jalr", -1);

    go("jal", 32'h008000EF, 1'b0, 1'b0, 1'b0);

    prep(32'h123450B7, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_lui_imm", 32'(q[2].imm), 32'd4);
    run("lui", -1);

    prep(32'h4020D1B3, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_sra_alu", 32'(q[2].alu), 32'd9);
    run("sra", -1);
    go("sub", 32'h402081B3, 1'b0, 1'b0, 1'b0);
    go("slt", 32'h0020A1B3, 1'b0, 1'b0, 1'b0);
    go("sltu", 32'h0020B1B3, 1'b0, 1'b0, 1'b0);

    prep(32'h40008093, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_addi_b30_alu", 32'(q[2].alu), 32'd0);
    run("addi_b30", -1);
    go("srai", 32'h4030D093, 1'b0, 1'b0, 1'b0);
    go("andi", 32'h0FF0F093, 1'b0, 1'b0, 1'b0);
    go("xori", 32'h0FF0C093, 1'b0, 1'b0, 1'b0);

    prep(32'h0020A023, 1'b0, 1'b0, 1'b0, 2, 1);
    check("model_sw_len", q.size(), 32'd7);
    run("sw_waits", -1);

    // Abort a stalled store: outputs must drop the moment rst rises
    prep(32'h0020A023, 1'b0, 1'b0, 1'b0, 0, 5);
    run("sw_abort", 4);
    exp_valid = 1'b0;
    bus.mem_ready = 1'b0;
    check("abort_pre_mem_w", 32'(bus.mem_w), 32'd1);
    #2 rst = 1'b1;
    #1 check("abort_outputs_zero", 32'(dut_v), 32'd0);
    @(posedge clk);
    #1 check("abort_hold_zero", 32'(dut_v), 32'd0);
    rst = 1'b0;
    #1 check("abort_fetch_req", 32'({bus.mem_req, bus.adr_src, bus.mem_w}), 32'b100);
    prep(32'h002081B3, 1'b0, 1'b0, 1'b0, 1, 0);
    run("add_after_abort", -1);

    prep(32'h0000007F, 1'b0, 1'b0, 1'b0, 0, 0);
    check("model_illegal_len", q.size(), TRAP_EN ? 32'd6 : 32'd2);
    run("illegal_op", -1);
    do_reset("ill_op");
    go("add_after_ill", 32'h002081B3, 1'b0, 1'b0, 1'b0);
    go("illegal_br", 32'h0020A063, 1'b1, 1'b1, 1'b1);
    do_reset("ill_br");
    go("lw_final", 32'h0000A183, 1'b0, 1'b0, 1'b0);
    exp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
